// File: rtl/volts_buf_pkg.sv
// rtl/volts_buf_pkg.sv - shared FSM encoding and length clamp for volts_buffer
package volts_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FETCH   = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

  // A requested length of zero, or one larger than the RAM, means "fill the RAM".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage

// File: rtl/volts_buffer_if.sv
// rtl/volts_buffer_if.sv - ADC capture / TX drain signal bundle for volts_buffer
// master: ADC side and TX side stimulus (start, len, samples, ready)
// slave : the buffer itself (drives dout, dout_valid, busy, done, count)
interface volts_buffer_if #(
  parameter int Width = 12,
  parameter int Depth = 32
);
  localparam int AddrW = $clog2(Depth);

  logic             start_i;
  logic [AddrW:0]   len_i;
  logic [Width-1:0] din_i;
  logic             din_valid_i;
  logic [Width-1:0] dout_o;
  logic             dout_valid_o;
  logic             dout_ready_i;
  logic             busy_o;
  logic             done_o;
  logic [AddrW:0]   count_o;

  modport master (
    output start_i, len_i, din_i, din_valid_i, dout_ready_i,
    input  dout_o, dout_valid_o, busy_o, done_o, count_o
  );

  modport slave (
    input  start_i, len_i, din_i, din_valid_i, dout_ready_i,
    output dout_o, dout_valid_o, busy_o, done_o, count_o
  );
endinterface

// File: rtl/ram_sp_sync.sv
// rtl/ram_sp_sync.sv - single-port RAM with registered read data
// clk_i   : clock
// we_i    : write wdata_i to addr_i
// re_i    : load rdata_o from addr_i (visible next cycle)
// addr_i  : shared read/write address
// wdata_i : write data
// rdata_o : read data, held between reads
module ram_sp_sync #(
  parameter int Width = 12,
  parameter int Depth = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rdata_q;

  // No reset on the array or the read register: the buffer contents are
  // only meaningful after they have been written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/volts_buffer.sv
// rtl/volts_buffer.sv - capture a burst of ADC samples, then drain it to TX
// clk_i  : system clock, rising edge
// rst_ni : synchronous active-low reset
// bus    : slave side of volts_buffer_if
//   start_i/len_i      start a capture burst of len_i samples (0 or >Depth -> Depth)
//   din_i/din_valid_i  ADC samples, written only while capturing
//   dout_o/dout_valid_o/dout_ready_i  drain handshake, one sample per 2 cycles max
//   busy_o  not idle; done_o  pulse after last sample accepted; count_o  samples captured
module volts_buffer
  import volts_buf_pkg::*;
#(
  parameter int Width = 12,
  parameter int Depth = 32
) (
  input logic         clk_i,
  input logic         rst_ni,
  volts_buffer_if.slave bus
);

  localparam int AddrW = $clog2(Depth);
  localparam int LenW  = AddrW + 1;

  state_e           state_q, state_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LenW-1:0]  count_q, count_d;
  logic             dout_valid_q, dout_valid_d;
  logic             done_q, done_d;

  logic             ram_we;
  logic             ram_re;
  logic [AddrW-1:0] ram_addr;
  logic [Width-1:0] ram_rdata;

  ram_sp_sync #(
    .Width(Width),
    .Depth(Depth)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (bus.din_i),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_valid_d = dout_valid_q;
    done_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          len_d    = LenW'(clamp_len(32'(bus.len_i), Depth));
          wr_ptr_d = '0;
          count_d  = '0;
          state_d  = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (bus.din_valid_i) begin
          wr_ptr_d = wr_ptr_q + AddrW'(1);
          count_d  = count_q + LenW'(1);
          if (count_d == len_q) begin
            rd_ptr_d = '0;
            state_d  = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        // RAM read issued this cycle; data lands as PRESENT begins.
        dout_valid_d = 1'b1;
        state_d      = ST_PRESENT;
      end

      ST_PRESENT: begin
        if (bus.dout_ready_i) begin
          dout_valid_d = 1'b0;
          if ({1'b0, rd_ptr_q} == len_q - LenW'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
            state_d  = ST_FETCH;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_we   = (state_q == ST_CAPTURE) && bus.din_valid_i;
    ram_re   = (state_q == ST_FETCH);
    ram_addr = ram_we ? wr_ptr_q : rd_ptr_q;
  end

  // The RAM read register only reloads in FETCH, so it holds the presented
  // sample steady under backpressure; gating keeps dout at zero otherwise.
  assign bus.dout_o       = dout_valid_q ? ram_rdata : '0;
  assign bus.dout_valid_o = dout_valid_q;
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.done_o       = done_q;
  assign bus.count_o      = count_q;

endmodule

// File: doc/volts_buffer.md
Name: volts_buffer

Overview:
- Parametrised capture/playback buffer for ADC voltage samples.
- Captures a programmable-length burst of samples from the ADC path into an internal synchronous RAM.
- Then drains the burst in address order to the serial TX path over a valid/ready handshake.
- Sits between the ADC sample interface and the UART/TX serialiser in the dac_adc_tx datapath.

Parameters:
- Width, 12, sample width in bits.
- Depth, 32, RAM depth in samples; must be a power of two, at least 2.
- AddrW, $clog2(Depth), address width; derived, not overridden.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_ni  in  1  synchronous active-low reset.
- start_i  in  1  one-cycle pulse; starts a capture burst when idle.
- len_i  in  AddrW+1  burst length, sampled on accepted start_i.
- din_i  in  Width  ADC sample.
- din_valid_i  in  1  din_i is valid this cycle.
- dout_o  out  Width  sample to TX.
- dout_valid_o  out  1  dout_o is valid.
- dout_ready_i  in  1  TX accepts dout_o.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when the last sample is accepted by TX.
- count_o  out  AddrW+1  samples captured in the current or last burst.

Behaviour:
- Reset: single clock, synchronous active-low reset rst_ni; clock is clk_i. When rst_ni=0 on a rising edge, the block enters IDLE.
  - Output reset values: dout_o=0, dout_valid_o=0, busy_o=0, done_o=0, count_o=0.
  - Internal pointers and the stored length are cleared.
  - RAM contents are not cleared.
  - Reset mid-burst aborts the burst with no done_o pulse.
- FSM states: IDLE, CAPTURE, FETCH, PRESENT.
- IDLE:
  - start_i=1 latches len; wr_ptr=0; count_o=0; next state CAPTURE.
  - len_i of 0 or greater than Depth is clamped to Depth.
  - din_valid_i is ignored, including in the same cycle as start_i.
- CAPTURE:
  - Each cycle with din_valid_i=1 writes din_i to RAM[wr_ptr], increments wr_ptr and increments count_o.
  - After the write that makes count equal len, go to FETCH with rd_ptr=0.
  - Samples arriving after that are dropped.
  - Gaps in din_valid_i are allowed and do not time out.
- FETCH:
  - Drives RAM read address rd_ptr for exactly one cycle.
  - RAM read is synchronous, 1-cycle latency.
  - Next state PRESENT.
- PRESENT:
  - dout_o is registered from RAM read data on entry and dout_valid_o=1.
  - dout_o is held stable while dout_valid_o=1 and dout_ready_i=0.
  - On dout_ready_i=1:
    - If rd_ptr equals len-1: done_o=1 for one cycle, dout_valid_o=0, next state IDLE.
    - Otherwise: rd_ptr increments, dout_valid_o=0, next state FETCH.
  - Drain throughput is at most one sample per 2 cycles.
  - dout_ready_i is ignored outside PRESENT.
- start_i outside IDLE is ignored.
- No write and read occur in the same cycle, so there is no RAM collision case.
- Wrap-around: pointers never exceed len-1 ≤ Depth-1, so the AddrW-bit address cannot wrap.
- count_o is AddrW+1 bits so it can represent Depth itself.
- count_o holds its value after done_o until the next accepted start_i.
- Latency: from the last capture write to dout_valid_o is 2 cycles (FETCH, then PRESENT).

Decomposition:
- Package volts_buf_pkg holds:
  - FSM state encoding (IDLE=0, CAPTURE=1, FETCH=2, PRESENT=3).
  - Length clamp helper function.
- Sub-module ram_sp_sync (params Width, Depth): single-port RAM.
  - Write when we_i=1.
  - Registered read data, 1-cycle latency.
  - No reset on the array.

Test Plan:
- Basic burst: reset, start_i with len_i=4, samples 0x100,0x200,0x300,0x400 back-to-back, dout_ready_i=1 -> dout_o emits 0x100..0x400 one every 2 cycles. done_o pulses once; count_o=4; busy_o=0 the following cycle.
- Full depth with clamp: len_i=0 and len_i=40 each capture 32 samples (ramp 0..31). Sample 33 (value 0xFFF) is not emitted. Output is 0..31; count_o=32.
- Backpressure: len_i=2, dout_ready_i low for 5 cycles in PRESENT -> dout_o stays 0xABC and dout_valid_o stays 1 throughout. The second sample appears only after ready is asserted.
- Ignored events:
  - start_i during CAPTURE -> no effect on len or ptrs.
  - din_valid_i in IDLE, including in the start cycle -> not stored; first output equals the first sample sent in CAPTURE.
  - din_valid_i gaps of 3 cycles -> no effect on the captured data.
- Reset mid-operation: rst_ni=0 in CAPTURE after 2 of 4 samples -> all outputs are at reset values next cycle with no done_o. A fresh burst then behaves as in the basic burst test.
